// File: rtl/nasti_mem_slave_if.sv
// nasti_channel: NASTI (AXI4 subset) channel bundle between a master and a
// responder.
//   AW: aw_valid/aw_ready, aw_id, aw_addr, aw_len, aw_size, aw_burst
//   W : w_valid/w_ready, w_data, w_strb, w_last
//   B : b_valid/b_ready, b_id, b_resp, b_user
//   AR: ar_valid/ar_ready, ar_id, ar_addr, ar_len, ar_size, ar_burst
//   R : r_valid/r_ready, r_id, r_data, r_resp, r_last, r_user
// The slave modport is the responder side and the master modport is the requester side.
interface nasti_channel #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned USER_WIDTH = 1
);
  logic                    aw_valid;
  logic                    aw_ready;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;

  logic                    w_valid;
  logic                    w_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;

  logic                    b_valid;
  logic                    b_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;

  logic                    r_valid;
  logic                    r_ready;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp, b_user,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, r_user,
    input  r_ready
  );

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp, b_user,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last, r_user,
    output r_ready
  );
endinterface

// File: rtl/nasti_mem_slave.sv
// nasti_mem_slave: terminating NASTI responder backed by an internal
// word-addressed RAM of MEM_WORDS x DATA_WIDTH.  Read and write channels run
// independent state machines.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   s   : nasti_channel.slave (AW/W/AR in, B/R out, AW/W/AR ready out)
// Optional feature: define NASTI_MEM_SLAVE_WRAP_EN to support WRAP bursts;
// otherwise WRAP is treated as an illegal burst type (all beats SLVERR).
module nasti_mem_slave #(
  parameter int unsigned           ID_WIDTH   = 1,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           USER_WIDTH = 1,
  parameter int unsigned           MEM_WORDS  = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic         clk,
  input  logic         rst,
  nasti_channel.slave  s
);

  localparam int unsigned NB     = DATA_WIDTH / 8;
  localparam int unsigned NB_LOG = $clog2(NB);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(MEM_WORDS * NB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef NASTI_MEM_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  // Borrow bit of the widened subtraction catches addresses below the base.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return !diff[ADDR_WIDTH] && (diff < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> NB_LOG);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [7:0] len,
                                                      input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] step, mask, res;
    step = ADDR_WIDTH'(1) << size;
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    case (burst)
      2'd1:    res = a + step;
      2'd2:    res = (a & ~mask) | ((a + step) & mask);
      default: res = a;
    endcase
    return res;
  endfunction

  function automatic logic burst_legal(input logic [1:0] burst,
                                       input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] step;
    logic wrap_ok, res;
    step    = ADDR_WIDTH'(1) << size;
    wrap_ok = WRAP_EN && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) &&
              ((a & (step - ADDR_WIDTH'(1))) == '0);
    case (burst)
      2'd0, 2'd1: res = 1'b1;
      2'd2:       res = wrap_ok;
      default:    res = 1'b0;
    endcase
    return res;
  endfunction

  // Outputs are held quiet during reset and for one full cycle after it.
  logic [1:0] hold_q;
  logic       quiet;

  always_ff @(posedge clk) begin
    if (rst) hold_q <= 2'b11;
    else     hold_q <= {hold_q[0], 1'b0};
  end
  assign quiet = |hold_q;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------- write
  wstate_e               w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q, w_cnt_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q;
  logic                  w_ok_q, w_err_q;
  logic                  aw_hs, w_hs, b_hs, w_fin, w_beat_ok;

  assign aw_hs     = s.aw_valid && s.aw_ready;
  assign w_hs      = s.w_valid && s.w_ready;
  assign b_hs      = s.b_valid && s.b_ready;
  assign w_fin     = (w_cnt_q == w_len_q);
  assign w_beat_ok = w_ok_q && in_range(w_addr_q);

  always_ff @(posedge clk) begin
    if (rst) w_state_q <= W_IDLE;
    else     w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs)         w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_fin) w_state_d = W_RESP;
      W_RESP:  if (b_hs)          w_state_d = W_IDLE;
      default:                    w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s.aw_ready = (w_state_q == W_IDLE) && !quiet;
    s.w_ready  = (w_state_q == W_DATA) && !quiet;
    s.b_valid  = (w_state_q == W_RESP) && !quiet;
    s.b_id     = s.b_valid ? w_id_q : '0;
    s.b_resp   = (s.b_valid && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    s.b_user   = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
      w_ok_q    <= 1'b0;
      w_err_q   <= 1'b0;
    end else if (aw_hs) begin
      w_id_q    <= s.aw_id;
      w_addr_q  <= s.aw_addr;
      w_len_q   <= s.aw_len;
      w_size_q  <= s.aw_size;
      w_burst_q <= s.aw_burst;
      w_cnt_q   <= '0;
      w_ok_q    <= burst_legal(s.aw_burst, s.aw_len, s.aw_size, s.aw_addr);
      w_err_q   <= 1'b0;
    end else if (w_hs) begin
      w_addr_q <= next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
      w_cnt_q  <= w_cnt_q + 8'd1;
      if (!w_beat_ok || (s.w_last != w_fin)) w_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_hs && w_beat_ok) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (s.w_strb[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= s.w_data[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  rstate_e               r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [ADDR_WIDTH-1:0] r_addr_q, rd_addr;
  logic [7:0]            r_len_q, r_cnt_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_burst_q;
  logic                  r_ok_q, r_err_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic                  ar_hs, r_hs, r_fin, rd_load, rd_ok;

  assign ar_hs   = s.ar_valid && s.ar_ready;
  assign r_hs    = s.r_valid && s.r_ready;
  assign r_fin   = (r_cnt_q == r_len_q);
  // The beat register is loaded one cycle ahead of presentation: from the AR
  // address on acceptance, then from the stepped address on each non-final
  // handshake, so beats stream back-to-back and hold steady under stall.
  assign rd_load = ar_hs || (r_hs && !r_fin);
  assign rd_addr = ar_hs ? s.ar_addr : next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
  assign rd_ok   = (ar_hs ? burst_legal(s.ar_burst, s.ar_len, s.ar_size, s.ar_addr) : r_ok_q) &&
                   in_range(rd_addr);

  always_ff @(posedge clk) begin
    if (rst) r_state_q <= R_IDLE;
    else     r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)         r_state_d = R_DATA;
      R_DATA:  if (r_hs && r_fin) r_state_d = R_IDLE;
      default:                    r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s.ar_ready = (r_state_q == R_IDLE) && !quiet;
    s.r_valid  = (r_state_q == R_DATA) && !quiet;
    s.r_id     = s.r_valid ? r_id_q : '0;
    s.r_last   = s.r_valid && r_fin;
    s.r_resp   = (s.r_valid && r_err_q) ? RESP_SLVERR : RESP_OKAY;
    s.r_data   = r_data_q;
    s.r_user   = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
      r_ok_q    <= 1'b0;
      r_err_q   <= 1'b0;
      r_data_q  <= '0;
    end else begin
      if (ar_hs) begin
        r_id_q    <= s.ar_id;
        r_len_q   <= s.ar_len;
        r_size_q  <= s.ar_size;
        r_burst_q <= s.ar_burst;
        r_cnt_q   <= '0;
        r_ok_q    <= burst_legal(s.ar_burst, s.ar_len, s.ar_size, s.ar_addr);
      end else if (r_hs && !r_fin) begin
        r_cnt_q <= r_cnt_q + 8'd1;
      end
      if (rd_load) begin
        r_addr_q <= rd_addr;
        r_err_q  <= !rd_ok;
        r_data_q <= rd_ok ? mem[word_idx(rd_addr)] : '0;
      end
    end
  end

endmodule

// File: tb/tb_nasti_mem_slave.sv
// Bench for nasti_mem_slave: directed and randomized bursts checked against
// a byte-array memory model with arithmetic beat-address generation.
module tb_nasti_mem_slave;
  localparam int unsigned IDW = 2, AW = 8, DW = 8, UW = 1, WORDS = 64;
  localparam int BASE = 0;
`ifdef NASTI_MEM_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nasti_channel #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)) bus ();

  nasti_mem_slave #(
    .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW),
    .MEM_WORDS(WORDS), .BASE_ADDR(8'h00)
  ) dut (.clk(clk), .rst(rst), .s(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [WORDS];
  logic [7:0] wd [256];
  bit         ws [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int a, input int len, input int size, input int burst);
    int step = 1 << size;
    if (burst == 0 || burst == 1) return 1'b1;
    if (burst == 2) return WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15) && (a % step == 0);
    return 1'b0;
  endfunction

  function automatic int beat_addr(input int a, input int len, input int size, input int burst, input int i);
    int step = 1 << size;
    int bound, base;
    if (burst == 1) return (a + i * step) % 256;
    if (burst == 2) begin
      bound = (len + 1) * step;
      base  = a - (a % bound);
      return base + ((a - base + i * step) % bound);
    end
    return a;
  endfunction

  function automatic bit inr(input int a);
    return a >= BASE && a < BASE + WORDS;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_aw_ready"}, bus.aw_ready, 0);
    chk({tag, "_ar_ready"}, bus.ar_ready, 0);
    chk({tag, "_w_ready"},  bus.w_ready, 0);
    chk({tag, "_b_valid"},  bus.b_valid, 0);
    chk({tag, "_r_valid"},  bus.r_valid, 0);
    chk({tag, "_r_last"},   bus.r_last, 0);
    chk({tag, "_resp"},     {bus.b_resp, bus.r_resp}, 0);
    chk({tag, "_ids"},      {bus.b_id, bus.r_id}, 0);
    chk({tag, "_r_data"},   bus.r_data, 0);
  endtask

  task automatic fill_rand(input int len);
    for (int i = 0; i <= len; i++) begin
      wd[i] = 8'($urandom);
      ws[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic write_burst(input int id, input int a, input int len, input int size,
                             input int burst, input int bad_last);
    int t;
    int ba;
    bit err, lst;
    err = !legal(a, len, size, burst);
    @(negedge clk);
    bus.aw_valid = 1'b1; bus.aw_id = IDW'(id); bus.aw_addr = AW'(a);
    bus.aw_len = 8'(len); bus.aw_size = 3'(size); bus.aw_burst = 2'(burst);
    t = 0;
    while (!bus.aw_ready && t < 100) begin @(negedge clk); t++; end
    chk("aw_accept", bus.aw_ready, 1);
    @(negedge clk);
    bus.aw_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      lst = (i == len) ^ (i == bad_last);
      bus.w_valid = 1'b1; bus.w_data = wd[i]; bus.w_strb = ws[i]; bus.w_last = lst;
      t = 0;
      while (!bus.w_ready && t < 100) begin @(negedge clk); t++; end
      chk("w_accept", bus.w_ready, 1);
      ba = beat_addr(a, len, size, burst, i);
      if (!legal(a, len, size, burst) || !inr(ba)) err = 1'b1;
      else if (ws[i]) ref_mem[ba - BASE] = wd[i];
      if (lst != (i == len)) err = 1'b1;
      @(negedge clk);
    end
    bus.w_valid = 1'b0; bus.w_last = 1'b0;
    bus.b_ready = 1'b1;
    t = 0;
    while (!bus.b_valid && t < 100) begin @(negedge clk); t++; end
    chk("b_gap", t, 0);
    chk("b_valid", bus.b_valid, 1);
    chk("b_id", bus.b_id, id);
    chk("b_resp", bus.b_resp, err ? 2 : 0);
    @(negedge clk);
    bus.b_ready = 1'b0;
  endtask

  task automatic read_burst(input int id, input int a, input int len, input int size,
                            input int burst, input int stall_beat, input int stall_n);
    int t, ba;
    bit ok;
    logic [7:0] ed;
    @(negedge clk);
    bus.ar_valid = 1'b1; bus.ar_id = IDW'(id); bus.ar_addr = AW'(a);
    bus.ar_len = 8'(len); bus.ar_size = 3'(size); bus.ar_burst = 2'(burst);
    t = 0;
    while (!bus.ar_ready && t < 100) begin @(negedge clk); t++; end
    chk("ar_accept", bus.ar_ready, 1);
    @(negedge clk);
    bus.ar_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      t = 0;
      while (!bus.r_valid && t < 100) begin @(negedge clk); t++; end
      chk("r_gap", t, 0);
      ba = beat_addr(a, len, size, burst, i);
      ok = legal(a, len, size, burst) && inr(ba);
      ed = ok ? ref_mem[ba - BASE] : 8'h00;
      chk("r_valid", bus.r_valid, 1);
      chk("r_data", bus.r_data, ed);
      chk("r_resp", bus.r_resp, ok ? 0 : 2);
      chk("r_last", bus.r_last, i == len);
      chk("r_id", bus.r_id, id);
      if (i == stall_beat) begin
        repeat (stall_n) begin
          @(negedge clk);
          chk("stall_valid", bus.r_valid, 1);
          chk("stall_data", bus.r_data, ed);
          chk("stall_resp", bus.r_resp, ok ? 0 : 2);
          chk("stall_last", bus.r_last, i == len);
        end
      end
      bus.r_ready = 1'b1;
      @(negedge clk);
      bus.r_ready = 1'b0;
    end
    chk("r_idle_after", bus.r_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.aw_valid = 0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0;
    bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0; bus.w_last = 0; bus.b_ready = 0;
    bus.ar_valid = 0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0;
    bus.r_ready = 0;

    // Reset, then one quiet cycle, then ready.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_quiet("rst");
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_rst");
    @(negedge clk);
    chk("aw_ready_up", bus.aw_ready, 1);
    chk("ar_ready_up", bus.ar_ready, 1);

    // Initialise the whole RAM through the bus.
    fill_rand(WORDS - 1);
    for (int i = 0; i < WORDS; i++) ws[i] = 1'b1;
    write_burst(0, 0, WORDS - 1, 0, 1, -1);

    // Single-beat write/read.
    wd[0] = 8'hA5; ws[0] = 1'b1;
    write_burst(1, 'h10, 0, 0, 1, -1);
    read_burst(2, 'h10, 0, 0, 1, -1, 0);

    // INCR len 3 with a stall on beat 2.
    for (int i = 0; i < 4; i++) begin wd[i] = 8'(i + 1); ws[i] = 1'b1; end
    write_burst(3, 'h00, 3, 0, 1, -1);
    read_burst(0, 'h00, 3, 0, 1, 1, 3);

    // FIXED burst lands all beats on one word.
    wd[0] = 8'd7; wd[1] = 8'd8; wd[2] = 8'd9; ws[0] = 1; ws[1] = 1; ws[2] = 1;
    write_burst(1, 'h05, 2, 0, 0, -1);
    read_burst(1, 'h05, 0, 0, 1, -1, 0);
    read_burst(1, 'h06, 0, 0, 1, -1, 0);

    // Just past the top of the RAM.
    wd[0] = 8'h3C; ws[0] = 1'b1;
    write_burst(2, BASE + WORDS, 0, 0, 1, -1);
    read_burst(2, BASE + WORDS, 0, 0, 1, -1, 0);
    // Last word in range.
    write_burst(2, BASE + WORDS - 1, 0, 0, 1, -1);
    read_burst(2, BASE + WORDS - 2, 1, 0, 1, -1, 0);

    // Early w_last.
    wd[0] = 8'h11; wd[1] = 8'h22; ws[0] = 1; ws[1] = 1;
    write_burst(3, 'h20, 1, 0, 1, 0);
    read_burst(3, 'h20, 1, 0, 1, -1, 0);

    // WRAP len 3 starting mid-window, then reserved burst type.
    for (int i = 0; i < 4; i++) begin wd[i] = 8'(i + 1); ws[i] = 1'b1; end
    write_burst(1, 'h0E, 3, 0, 2, -1);
    read_burst(1, 'h0C, 3, 0, 1, -1, 0);
    read_burst(2, 'h0E, 3, 0, 2, 2, 1);
    fill_rand(1);
    write_burst(0, 'h30, 1, 0, 3, -1);
    read_burst(0, 'h30, 1, 0, 3, -1, 0);

    // Longest burst: 256 beats, in range then out of range.
    read_burst(3, 'h00, 255, 0, 1, 200, 2);

    // Randomized bursts.
    for (int n = 0; n < 30; n++) begin
      int a, len, size, burst, id;
      a = $urandom_range(0, 79); len = $urandom_range(0, 7);
      size = $urandom_range(0, 2); burst = $urandom_range(0, 3); id = $urandom_range(0, 3);
      fill_rand(len);
      write_burst(id, a, len, size, burst, ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1);
      read_burst(id ^ 1, a, len, size, burst, $urandom_range(0, len), $urandom_range(0, 2));
    end

    // Full readback.
    read_burst(0, 0, WORDS - 1, 0, 1, 10, 1);

    // Reset in the middle of a write burst; the first beat stays written.
    @(negedge clk);
    bus.aw_valid = 1; bus.aw_id = 2'd1; bus.aw_addr = 8'h20; bus.aw_len = 8'd3; bus.aw_size = 0; bus.aw_burst = 2'd1;
    @(negedge clk);
    bus.aw_valid = 0;
    bus.w_valid = 1; bus.w_data = 8'h5A; bus.w_strb = 1'b1; bus.w_last = 0;
    chk("mid_w_ready", bus.w_ready, 1);
    ref_mem[8'h20 - BASE] = 8'h5A;
    @(negedge clk);
    bus.w_valid = 0;
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("mid_rst");
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("mid_post_rst");
    wd[0] = 8'hC3; ws[0] = 1'b1;
    write_burst(2, 'h21, 0, 0, 1, -1);
    read_burst(1, 'h20, 1, 0, 1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
